// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the priority-evaluation pixel path
package pe_pkg;

  localparam int PE_LINE_PIXELS = 240;

  typedef logic [14:0] pe_color_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_LINE = 1'b1
  } pe_rd_state_t;

endpackage

// File: rtl/pe_line_bank.sv
// rtl/pe_line_bank.sv - one scanline of pixel storage with registered read port
// Ports:
//   clk     : clock
//   rst_b   : asynchronous active-low reset of the read data register
//   i_clr   : synchronous clear of the read data register
//   i_we    : write enable
//   i_waddr : write pixel index
//   i_wdata : write pixel colour
//   i_re    : read enable, data appears on o_rdata after the edge
//   i_raddr : read pixel index
//   o_rdata : read data, holds its value while i_re is low
module pe_line_bank #(
  parameter int DEPTH = 240,
  parameter int W     = 15,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Array contents are not reset; only lines marked full are ever read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      o_rdata <= '0;
    end else if (i_clr) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/pe_register.sv
// rtl/pe_register.sv - enabled register with async reset and synchronous clear
// Ports:
//   clk    : clock
//   rst_b  : asynchronous active-low reset, forces o_q to 0
//   i_clr  : synchronous clear to 0, wins over i_en
//   i_en   : load enable
//   i_d    : next value
//   o_q    : registered value
module pe_register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/pe_scanline_streamer.sv
// rtl/pe_scanline_streamer.sv - double-buffered scanline store between priority evaluation and LCD
// Optional feature macro: PE_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
// Ports:
//   clk          : system clock
//   rst_b        : asynchronous active-low reset
//   flush        : synchronous clear of banks, pointers and read state
//   pe_valid     : evaluated pixel present
//   pe_color     : evaluated pixel colour
//   pe_ready     : a pixel can be accepted this cycle
//   lcd_tick     : dot-clock enable, requests one output pixel
//   lcd_valid    : lcd_color valid, one-cycle pulse
//   lcd_color    : output pixel, holds between pulses
//   lcd_hsync    : qualifies lcd_valid for pixel x=0
//   underrun     : one-cycle pulse, tick arrived with no line ready
//   underrun_cnt : saturating underrun count (PE_UNDERRUN_CNT_EN only)
module pe_scanline_streamer
  import pe_pkg::*;
#(
  parameter int LINE_PIXELS = PE_LINE_PIXELS,
  parameter int COLOR_W     = 15
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               flush,
  input  logic               pe_valid,
  input  logic [COLOR_W-1:0] pe_color,
  output logic               pe_ready,
  input  logic               lcd_tick,
  output logic               lcd_valid,
  output logic [COLOR_W-1:0] lcd_color,
  output logic               lcd_hsync,
  output logic               underrun
`ifdef PE_UNDERRUN_CNT_EN
  ,
  output logic [7:0]         underrun_cnt
`endif
);

  localparam int             X_W    = $clog2(LINE_PIXELS);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_PIXELS - 1);
  localparam logic [X_W-1:0] X_ZERO = '0;
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);

  pe_rd_state_t r_state;
  pe_rd_state_t w_state_nxt;

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic [X_W-1:0]     r_wr_x;
  logic               r_rd_bank;
  logic [X_W-1:0]     r_rd_x;
  logic               r_lcd_valid;
  logic               r_lcd_hsync;
  logic               r_underrun;
  logic               r_out_bank;

  logic               w_accept;
  logic               w_wr_last;
  logic [X_W-1:0]     w_wr_x_d;
  logic               w_line_start;
  logic               w_rd_tick;
  logic               w_rd_last;
  logic               w_underrun_d;
  logic               w_hsync_d;
  logic               w_rd_x_en;
  logic [X_W-1:0]     w_rd_x_d;
  logic [1:0]         w_full_set;
  logic [1:0]         w_full_clr;
  logic [1:0]         w_full_d;
  logic [1:0]         w_we;
  logic [1:0]         w_re;
  logic [COLOR_W-1:0] w_rdata0;
  logic [COLOR_W-1:0] w_rdata1;

  // ---------------- write side ----------------
  assign pe_ready  = ~r_full[r_wr_bank];
  assign w_accept  = pe_valid & pe_ready & ~flush;
  assign w_wr_last = w_accept & (r_wr_x == X_LAST);
  assign w_wr_x_d  = w_wr_last ? X_ZERO : r_wr_x + X_ONE;
  assign w_we      = {w_accept & r_wr_bank, w_accept & ~r_wr_bank};

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= RD_IDLE;
    end else if (flush) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_LINE;
      RD_LINE: if (w_rd_last) w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_line_start = 1'b0;
    w_rd_tick    = 1'b0;
    w_underrun_d = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_line_start = r_full[r_rd_bank];
        w_underrun_d = lcd_tick;
      end
      RD_LINE: begin
        w_rd_tick = lcd_tick;
      end
      default: begin
        w_rd_tick = 1'b0;
      end
    endcase
  end

  assign w_rd_last = w_rd_tick & (r_rd_x == X_LAST);
  assign w_hsync_d = w_rd_tick & (r_rd_x == X_ZERO);
  assign w_rd_x_en = w_line_start | w_rd_tick;
  assign w_rd_x_d  = (w_line_start | w_rd_last) ? X_ZERO : r_rd_x + X_ONE;
  assign w_re      = {w_rd_tick & r_rd_bank, w_rd_tick & ~r_rd_bank};

  // Writer fills one bank while the reader drains the other, so a set and a
  // clear in the same cycle always target different bits and both apply.
  assign w_full_set = {w_wr_last & r_wr_bank, w_wr_last & ~r_wr_bank};
  assign w_full_clr = {w_rd_last & r_rd_bank, w_rd_last & ~r_rd_bank};
  assign w_full_d   = (r_full | w_full_set) & ~w_full_clr;

  // ---------------- pointer and flag registers ----------------
  pe_register #(.W(2)) u_full (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(1'b1), .i_d(w_full_d), .o_q(r_full)
  );
  pe_register #(.W(1)) u_wr_bank (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(w_wr_last), .i_d(~r_wr_bank), .o_q(r_wr_bank)
  );
  pe_register #(.W(X_W)) u_wr_x (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(w_accept), .i_d(w_wr_x_d), .o_q(r_wr_x)
  );
  pe_register #(.W(1)) u_rd_bank (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(w_rd_last), .i_d(~r_rd_bank), .o_q(r_rd_bank)
  );
  pe_register #(.W(X_W)) u_rd_x (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(w_rd_x_en), .i_d(w_rd_x_d), .o_q(r_rd_x)
  );
  pe_register #(.W(1)) u_lcd_valid (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(1'b1), .i_d(w_rd_tick), .o_q(r_lcd_valid)
  );
  pe_register #(.W(1)) u_lcd_hsync (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(1'b1), .i_d(w_hsync_d), .o_q(r_lcd_hsync)
  );
  pe_register #(.W(1)) u_underrun (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(1'b1), .i_d(w_underrun_d), .o_q(r_underrun)
  );
  // Remembers which bank produced the last pixel so lcd_color holds it between ticks.
  pe_register #(.W(1)) u_out_bank (
    .clk(clk), .rst_b(rst_b), .i_clr(flush), .i_en(w_rd_tick), .i_d(r_rd_bank), .o_q(r_out_bank)
  );

  // ---------------- line memories ----------------
  pe_line_bank #(.DEPTH(LINE_PIXELS), .W(COLOR_W), .AW(X_W)) u_bank0 (
    .clk(clk), .rst_b(rst_b), .i_clr(flush),
    .i_we(w_we[0]), .i_waddr(r_wr_x), .i_wdata(pe_color),
    .i_re(w_re[0]), .i_raddr(r_rd_x), .o_rdata(w_rdata0)
  );
  pe_line_bank #(.DEPTH(LINE_PIXELS), .W(COLOR_W), .AW(X_W)) u_bank1 (
    .clk(clk), .rst_b(rst_b), .i_clr(flush),
    .i_we(w_we[1]), .i_waddr(r_wr_x), .i_wdata(pe_color),
    .i_re(w_re[1]), .i_raddr(r_rd_x), .o_rdata(w_rdata1)
  );

  assign lcd_valid = r_lcd_valid;
  assign lcd_hsync = r_lcd_hsync;
  assign underrun  = r_underrun;
  assign lcd_color = r_out_bank ? w_rdata1 : w_rdata0;

`ifdef PE_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  // Counts alongside the pulse and sticks at 255.
  pe_register #(.W(8)) u_underrun_cnt (
    .clk(clk), .rst_b(rst_b), .i_clr(flush),
    .i_en(w_underrun_d & (r_underrun_cnt != 8'hFF)),
    .i_d(r_underrun_cnt + 8'd1), .o_q(r_underrun_cnt)
  );

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_pe_scanline_streamer.sv
// tb/tb_pe_scanline_streamer.sv - directed self-checking bench for pe_scanline_streamer
module tb_pe_scanline_streamer;
  import pe_pkg::*;

  localparam int LP = 240;

  logic      clk      = 1'b0;
  logic      rst_b    = 1'b0;
  logic      flush    = 1'b0;
  logic      pe_valid = 1'b0;
  pe_color_t pe_color = '0;
  logic      pe_ready;
  logic      lcd_tick = 1'b0;
  logic      lcd_valid;
  pe_color_t lcd_color;
  logic      lcd_hsync;
  logic      underrun;
`ifdef PE_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_scanline_streamer #(.LINE_PIXELS(LP), .COLOR_W(15)) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .pe_valid(pe_valid), .pe_color(pe_color), .pe_ready(pe_ready),
    .lcd_tick(lcd_tick), .lcd_valid(lcd_valid), .lcd_color(lcd_color),
    .lcd_hsync(lcd_hsync), .underrun(underrun)
`ifdef PE_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int base);
    for (int i = 0; i < LP; i++) begin
      pe_valid = 1'b1;
      pe_color = 15'(base + i);
      step();
    end
    pe_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (pe_ready !== 1'b1 || lcd_valid !== 1'b0 || lcd_hsync !== 1'b0 ||
        lcd_color !== 15'd0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b hsync=%b color=%0d underrun=%b, need 1 0 0 0 0",
               pe_ready, lcd_valid, lcd_hsync, lcd_color, underrun);
    end
    @(negedge clk);
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 5; i++) begin
      lcd_tick = 1'b1;
      step();
      checks++;
      if (underrun !== 1'b1 || lcd_valid !== 1'b0) begin
        failures++;
        $display("FAIL underrun_tick%0d: underrun=%b valid=%b, need 1 0", i, underrun, lcd_valid);
      end
    end
`ifdef PE_UNDERRUN_CNT_EN
    for (int i = 0; i < 295; i++) step();
    checks++;
    if (underrun_cnt !== 8'd255) begin
      failures++;
      $display("FAIL underrun_cnt_sat: got %0d, need 255", underrun_cnt);
    end
`endif
    lcd_tick = 1'b0;
    step();
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_idle: got %b, need 0", underrun);
    end
  endtask

  task automatic test_line();
    write_line(0);
    // Tick at the edge right after the last write: FSM still idle.
    lcd_tick = 1'b1;
    step();
    checks++;
    if (underrun !== 1'b1 || lcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL line_early_tick: underrun=%b valid=%b, need 1 0", underrun, lcd_valid);
    end
    for (int i = 0; i < LP; i++) begin
      step();
      checks++;
      if (lcd_valid !== 1'b1 || lcd_color !== 15'(i) || lcd_hsync !== (i == 0) || underrun !== 1'b0) begin
        failures++;
        $display("FAIL line_pixel%0d: valid=%b color=%0d hsync=%b underrun=%b, need 1 %0d %b 0",
                 i, lcd_valid, lcd_color, lcd_hsync, underrun, i, (i == 0));
      end
    end
    lcd_tick = 1'b0;
    step();
    checks++;
    if (lcd_valid !== 1'b0 || lcd_hsync !== 1'b0 || lcd_color !== 15'd239) begin
      failures++;
      $display("FAIL line_hold: valid=%b hsync=%b color=%0d, need 0 0 239", lcd_valid, lcd_hsync, lcd_color);
    end
  endtask

  task automatic test_fill_both();
    int bad_ready;
    bad_ready = 0;
    for (int i = 0; i < 2 * LP; i++) begin
      pe_valid = 1'b1;
      pe_color = 15'(1000 + i);
      if (pe_ready !== 1'b1) bad_ready++;
      step();
    end
    pe_valid = 1'b0;
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL fill_ready_high: %0d cycles with ready low, need 0", bad_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pe_ready !== 1'b0) begin
        failures++;
        $display("FAIL fill_ready_low%0d: got %b, need 0", i, pe_ready);
      end
    end
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < LP; i++) begin
        lcd_tick = 1'b1;
        step();
        checks++;
        if (lcd_valid !== 1'b1 || lcd_color !== 15'(1000 + ln * LP + i) || lcd_hsync !== (i == 0)) begin
          failures++;
          $display("FAIL fill_line%0d_pixel%0d: valid=%b color=%0d hsync=%b, need 1 %0d %b",
                   ln, i, lcd_valid, lcd_color, lcd_hsync, 1000 + ln * LP + i, (i == 0));
        end
        if (ln == 0 && i == LP - 2) begin
          checks++;
          if (pe_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_ready_before_drain: got %b, need 0", pe_ready);
          end
        end
      end
      lcd_tick = 1'b0;
      if (ln == 0) begin
        checks++;
        if (pe_ready !== 1'b1) begin
          failures++;
          $display("FAIL fill_ready_after_drain: got %b, need 1", pe_ready);
        end
      end
      step();
    end
  endtask

  task automatic test_concurrent();
    int wr_n;
    int out_n;
    int cyc;
    logic acc;
    write_line(2000);
    wr_n  = 0;
    out_n = 0;
    cyc   = 0;
    while (out_n < 2 * LP && cyc < 3000) begin
      lcd_tick = 1'b1;
      pe_valid = (wr_n < LP) ? 1'($urandom_range(0, 1)) : 1'b0;
      pe_color = 15'(2000 + LP + wr_n);
      acc = pe_valid & pe_ready;
      step();
      cyc++;
      if (acc) wr_n++;
      if (lcd_valid === 1'b1) begin
        checks++;
        if (lcd_color !== 15'(2000 + out_n) || lcd_hsync !== ((out_n % LP) == 0)) begin
          failures++;
          $display("FAIL concurrent_pixel%0d: color=%0d hsync=%b, need %0d %b",
                   out_n, lcd_color, lcd_hsync, 2000 + out_n, ((out_n % LP) == 0));
        end
        out_n++;
      end
    end
    lcd_tick = 1'b0;
    pe_valid = 1'b0;
    checks++;
    if (out_n != 2 * LP) begin
      failures++;
      $display("FAIL concurrent_timeout: got %0d pixels, need %0d", out_n, 2 * LP);
    end
    step();
  endtask

  task automatic test_flush();
    write_line(5000);
    step();
    for (int i = 0; i < 3; i++) begin
      lcd_tick = 1'b1;
      step();
    end
    lcd_tick = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pe_valid = 1'b1;
      pe_color = 15'(5240 + i);
      step();
    end
    pe_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (pe_ready !== 1'b1 || lcd_valid !== 1'b0 || lcd_color !== 15'd0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL flush_values: ready=%b valid=%b color=%0d underrun=%b, need 1 0 0 0",
               pe_ready, lcd_valid, lcd_color, underrun);
    end
    for (int i = 0; i < 2; i++) begin
      lcd_tick = 1'b1;
      step();
      checks++;
      if (underrun !== 1'b1 || lcd_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_idle_tick%0d: underrun=%b valid=%b, need 1 0", i, underrun, lcd_valid);
      end
    end
    lcd_tick = 1'b0;
    write_line(6000);
    step();
    for (int i = 0; i < LP; i++) begin
      lcd_tick = 1'b1;
      step();
      checks++;
      if (lcd_valid !== 1'b1 || lcd_color !== 15'(6000 + i) || lcd_hsync !== (i == 0)) begin
        failures++;
        $display("FAIL flush_newline_pixel%0d: valid=%b color=%0d hsync=%b, need 1 %0d %b",
                 i, lcd_valid, lcd_color, lcd_hsync, 6000 + i, (i == 0));
      end
    end
    lcd_tick = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    write_line(7000);
    step();
    lcd_tick = 1'b1;
    step();
    checks++;
    if (lcd_valid !== 1'b1 || lcd_hsync !== 1'b1 || lcd_color !== 15'd7000) begin
      failures++;
      $display("FAIL areset_pre: valid=%b hsync=%b color=%0d, need 1 1 7000", lcd_valid, lcd_hsync, lcd_color);
    end
    #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if (pe_ready !== 1'b1 || lcd_valid !== 1'b0 || lcd_hsync !== 1'b0 ||
        lcd_color !== 15'd0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL areset_async: ready=%b valid=%b hsync=%b color=%0d underrun=%b, need 1 0 0 0 0",
               pe_ready, lcd_valid, lcd_hsync, lcd_color, underrun);
    end
    lcd_tick = 1'b0;
    #1;
    rst_b = 1'b1;
    step();
    lcd_tick = 1'b1;
    step();
    lcd_tick = 1'b0;
    checks++;
    if (underrun !== 1'b1 || lcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_idle_tick: underrun=%b valid=%b, need 1 0", underrun, lcd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_line();
    test_fill_both();
    test_concurrent();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
